// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer
// Frame controller for the pixel array: walks erase/expose/convert/read12/read34
// phases with run-time programmable lengths, captures the four pixel words at the
// end of the read phases and drains them as a valid/ready byte stream.
module pixel_frame_sequencer #(
    parameter logic [7:0] DEF_ERASE   = 8'd5,
    parameter logic [7:0] DEF_EXPOSE  = 8'd255,
    parameter logic [7:0] DEF_CONVERT = 8'd255,
    parameter logic [7:0] DEF_READ    = 8'd5,
    parameter int         CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cfg_we,
    input  logic [1:0]       i_cfg_addr,
    input  logic [7:0]       i_cfg_wdata,
    input  logic             i_start,
    input  logic             i_continuous,
    input  logic             i_abort,
    input  logic [7:0]       i_pix_in1,
    input  logic [7:0]       i_pix_in2,
    input  logic [7:0]       i_pix_in3,
    input  logic [7:0]       i_pix_in4,
    output logic             o_erase,
    output logic             o_expose,
    output logic             o_convert,
    output logic             o_read12,
    output logic             o_read34,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic [CNT_W-1:0] o_frame_count,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [7:0]       o_out_data,
    output logic [1:0]       o_out_idx
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ12  = 3'd4,
        ST_READ34  = 3'd5,
        ST_DRAIN   = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next;

    // Programmed lengths (written any time) and the per-frame copies in use.
    logic [7:0]       r_len_erase;
    logic [7:0]       r_len_expose;
    logic [7:0]       r_len_convert;
    logic [7:0]       r_len_read;
    logic [7:0]       r_act_expose;
    logic [7:0]       r_act_convert;
    logic [7:0]       r_act_read;

    logic [7:0]       r_cnt;
    logic [7:0]       r_buf [4];

    logic             r_erase;
    logic             r_expose;
    logic             r_convert;
    logic             r_read12;
    logic             r_read34;
    logic             r_busy;
    logic             r_frame_done;
    logic [CNT_W-1:0] r_frame_count;
    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic [1:0]       r_out_idx;

    logic             w_last;
    logic             w_accept;
    logic             w_frame_end;
    logic             w_enter;
    logic [1:0]       w_idx_inc;

    // A length of N gives N cycles; zero is stretched to one cycle.
    function automatic logic [7:0] f_load(input logic [7:0] len);
        return (len == 8'd0) ? 8'd0 : (len - 8'd1);
    endfunction

    assign w_last      = (r_cnt == 8'd0);
    assign w_accept    = r_out_valid & i_out_ready;
    assign w_frame_end = (r_state == ST_DRAIN) && w_accept && (r_out_idx == 2'd3) && !i_abort;
    assign w_enter     = (w_next != r_state);
    assign w_idx_inc   = r_out_idx + 2'd1;

    assign o_erase       = r_erase;
    assign o_expose      = r_expose;
    assign o_convert     = r_convert;
    assign o_read12      = r_read12;
    assign o_read34      = r_read34;
    assign o_busy        = r_busy;
    assign o_frame_done  = r_frame_done;
    assign o_frame_count = r_frame_count;
    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;
    assign o_out_idx     = r_out_idx;

    // Next-state selection; abort overrides everything.
    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (i_start) w_next = ST_ERASE;   else w_next = ST_IDLE;
                ST_ERASE:   if (w_last)  w_next = ST_EXPOSE;  else w_next = ST_ERASE;
                ST_EXPOSE:  if (w_last)  w_next = ST_CONVERT; else w_next = ST_EXPOSE;
                ST_CONVERT: if (w_last)  w_next = ST_READ12;  else w_next = ST_CONVERT;
                ST_READ12:  if (w_last)  w_next = ST_READ34;  else w_next = ST_READ12;
                ST_READ34:  if (w_last)  w_next = ST_DRAIN;   else w_next = ST_READ34;
                ST_DRAIN: begin
                    if (w_frame_end) w_next = i_continuous ? ST_ERASE : ST_IDLE;
                    else             w_next = ST_DRAIN;
                end
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    // State register plus Moore strobes decoded from the next state so they track the state exactly.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_erase     <= 1'b0;
            r_expose    <= 1'b0;
            r_convert   <= 1'b0;
            r_read12    <= 1'b0;
            r_read34    <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_erase     <= (w_next == ST_ERASE);
            r_expose    <= (w_next == ST_EXPOSE);
            r_convert   <= (w_next == ST_CONVERT);
            r_read12    <= (w_next == ST_READ12);
            r_read34    <= (w_next == ST_READ34);
            r_busy      <= (w_next != ST_IDLE);
            r_out_valid <= (w_next == ST_DRAIN);
        end
    end

    // Length registers; also snapshot the later-phase lengths when a frame enters erase.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_len_erase   <= DEF_ERASE;
            r_len_expose  <= DEF_EXPOSE;
            r_len_convert <= DEF_CONVERT;
            r_len_read    <= DEF_READ;
            r_act_expose  <= DEF_EXPOSE;
            r_act_convert <= DEF_CONVERT;
            r_act_read    <= DEF_READ;
        end else begin
            if (i_cfg_we) begin
                case (i_cfg_addr)
                    2'd0:    r_len_erase   <= i_cfg_wdata;
                    2'd1:    r_len_expose  <= i_cfg_wdata;
                    2'd2:    r_len_convert <= i_cfg_wdata;
                    2'd3:    r_len_read    <= i_cfg_wdata;
                    default: r_len_erase   <= r_len_erase;
                endcase
            end
            if (w_enter && (w_next == ST_ERASE)) begin
                r_act_expose  <= r_len_expose;
                r_act_convert <= r_len_convert;
                r_act_read    <= r_len_read;
            end
        end
    end

    // Phase down-counter: loaded on every phase entry, phase ends when it reads zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= 8'd0;
        end else if (w_enter) begin
            case (w_next)
                ST_ERASE:   r_cnt <= f_load(r_len_erase);
                ST_EXPOSE:  r_cnt <= f_load(r_act_expose);
                ST_CONVERT: r_cnt <= f_load(r_act_convert);
                ST_READ12:  r_cnt <= f_load(r_act_read);
                ST_READ34:  r_cnt <= f_load(r_act_read);
                default:    r_cnt <= 8'd0;
            endcase
        end else if (!w_last) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    // Capture pixel pairs on the last cycle of each read phase (skipped on abort).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 4; i++) r_buf[i] <= 8'd0;
        end else begin
            if ((r_state == ST_READ12) && (w_next == ST_READ34)) begin
                r_buf[0] <= i_pix_in1;
                r_buf[1] <= i_pix_in2;
            end
            if ((r_state == ST_READ34) && (w_next == ST_DRAIN)) begin
                r_buf[2] <= i_pix_in3;
                r_buf[3] <= i_pix_in4;
            end
        end
    end

    // Stream word/index: present word 0 on drain entry, step on each accepted word.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out_data <= 8'd0;
            r_out_idx  <= 2'd0;
        end else if ((r_state != ST_DRAIN) && (w_next == ST_DRAIN)) begin
            r_out_data <= r_buf[0];
            r_out_idx  <= 2'd0;
        end else if ((r_state == ST_DRAIN) && w_accept && !i_abort && (r_out_idx != 2'd3)) begin
            r_out_data <= r_buf[w_idx_inc];
            r_out_idx  <= w_idx_inc;
        end
    end

    // Frame completion pulse and wrapping frame counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_frame_done  <= 1'b0;
            r_frame_count <= {CNT_W{1'b0}};
        end else begin
            r_frame_done <= w_frame_end;
            if (w_frame_end) r_frame_count <= r_frame_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Scoreboard bench for pixel_frame_sequencer: stimulus pushes expected phase
// widths, stream words and frame counts; monitors pop and compare on DUT output.
module tb_pixel_frame_sequencer;

    logic        clk = 1'b0;
    logic        i_reset, i_cfg_we, i_start, i_continuous, i_abort, i_out_ready;
    logic [1:0]  i_cfg_addr;
    logic [7:0]  i_cfg_wdata, i_pix_in1, i_pix_in2, i_pix_in3, i_pix_in4;
    logic        o_erase, o_expose, o_convert, o_read12, o_read34;
    logic        o_busy, o_frame_done, o_out_valid;
    logic [15:0] o_frame_count;
    logic [7:0]  o_out_data;
    logic [1:0]  o_out_idx;

    typedef struct { logic [4:0] vec; int len; } phase_t;
    typedef struct { logic [7:0] data; logic [1:0] idx; } word_t;

    phase_t      pq[$];
    word_t       wq[$];
    logic [15:0] dq[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          ph_en = 1'b1;
    int          rdy_mode = 0;

    localparam logic [4:0] V_E = 5'b10000, V_X = 5'b01000, V_C = 5'b00100,
                           V_R12 = 5'b00010, V_R34 = 5'b00001;

    always #5 clk = ~clk;

    pixel_frame_sequencer dut (
        .i_clk(clk), .i_reset(i_reset), .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr),
        .i_cfg_wdata(i_cfg_wdata), .i_start(i_start), .i_continuous(i_continuous),
        .i_abort(i_abort), .i_pix_in1(i_pix_in1), .i_pix_in2(i_pix_in2),
        .i_pix_in3(i_pix_in3), .i_pix_in4(i_pix_in4), .o_erase(o_erase),
        .o_expose(o_expose), .o_convert(o_convert), .o_read12(o_read12),
        .o_read34(o_read34), .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_frame_count(o_frame_count), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready), .o_out_data(o_out_data), .o_out_idx(o_out_idx)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    function automatic int eff(input int len);
        return (len == 0) ? 1 : len;
    endfunction

    task automatic push_frame(input int e, input int x, input int c, input int r,
                              input logic [7:0] p1, input logic [7:0] p2,
                              input logic [7:0] p3, input logic [7:0] p4,
                              input logic [15:0] cnt);
        pq.push_back('{V_E, eff(e)});
        pq.push_back('{V_X, eff(x)});
        pq.push_back('{V_C, eff(c)});
        pq.push_back('{V_R12, eff(r)});
        pq.push_back('{V_R34, eff(r)});
        wq.push_back('{p1, 2'd0});
        wq.push_back('{p2, 2'd1});
        wq.push_back('{p3, 2'd2});
        wq.push_back('{p4, 2'd3});
        dq.push_back(cnt);
    endtask

    task automatic set_pix(input logic [7:0] p1, input logic [7:0] p2,
                           input logic [7:0] p3, input logic [7:0] p4);
        i_pix_in1 = p1; i_pix_in2 = p2; i_pix_in3 = p3; i_pix_in4 = p4;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        i_cfg_we = 1'b1; i_cfg_addr = a; i_cfg_wdata = d;
        @(posedge clk); #1;
        i_cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge clk); #1 i_abort = 1'b1;
        @(posedge clk); #1 i_abort = 1'b0;
    endtask

    // Waits (bounded) until the selected DUT output is seen high at a falling edge.
    task automatic wait_for(input int sel, input int budget, input string nm);
        int  k;
        bit  hit;
        k = 0;
        hit = 1'b0;
        while (!hit && (k < budget)) begin
            @(negedge clk);
            k++;
            case (sel)
                0:       hit = o_convert;
                1:       hit = o_out_valid;
                2:       hit = o_expose;
                default: hit = o_frame_done;
            endcase
        end
        if (!hit) flag({"timeout_", nm});
    endtask

    task automatic chk_idle_outputs(input string nm, input logic [15:0] cnt);
        chk({nm, "_ctl"}, 32'({o_erase, o_expose, o_convert, o_read12, o_read34,
                                o_busy, o_frame_done, o_out_valid}), 32'd0);
        chk({nm, "_count"}, 32'(o_frame_count), 32'(cnt));
    endtask

    // Ready generator: 0 = always ready, 1 = toggle every cycle, other = hold.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0)      i_out_ready = 1'b1;
            else if (rdy_mode == 1) i_out_ready = ~i_out_ready;
        end
    end

    // Phase monitor: measures each strobe run and compares against the expected width.
    initial begin
        logic [4:0] prev_vec, cur;
        int         runlen;
        phase_t     p;
        prev_vec = 5'd0;
        runlen = 0;
        forever begin
            @(negedge clk);
            cur = {o_erase, o_expose, o_convert, o_read12, o_read34};
            if (cur != 5'd0) chk("strobe_onehot", 32'($onehot(cur)), 32'd1);
            if (cur != prev_vec) begin
                if ((prev_vec != 5'd0) && ph_en) begin
                    if (pq.size() == 0) flag("phase_unexpected");
                    else begin
                        p = pq.pop_front();
                        chk("phase_vec", 32'(prev_vec), 32'(p.vec));
                        chk("phase_len", 32'(runlen), 32'(p.len));
                    end
                end
                runlen = 1;
            end else begin
                runlen++;
            end
            prev_vec = cur;
        end
    end

    // Word monitor: every valid cycle must show the queue head; pop on acceptance.
    initial begin
        forever begin
            @(negedge clk);
            if (o_out_valid) begin
                if (wq.size() == 0) flag("word_unexpected");
                else begin
                    chk("word_data", 32'(o_out_data), 32'(wq[0].data));
                    chk("word_idx", 32'(o_out_idx), 32'(wq[0].idx));
                    if (i_out_ready) void'(wq.pop_front());
                end
            end
        end
    end

    // Frame-done monitor: each pulse pops the expected completed-frame count.
    initial begin
        forever begin
            @(negedge clk);
            if (o_frame_done) begin
                if (dq.size() == 0) flag("frame_done_unexpected");
                else chk("frame_count", 32'(o_frame_count), 32'(dq.pop_front()));
            end
        end
    end

    initial begin
        i_reset = 1'b1; i_cfg_we = 1'b0; i_cfg_addr = 2'd0; i_cfg_wdata = 8'd0;
        i_start = 1'b0; i_continuous = 1'b0; i_abort = 1'b0; i_out_ready = 1'b1;
        set_pix(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset", 16'd0);
        chk("reset_data", 32'({o_out_data, o_out_idx}), 32'd0);
        @(posedge clk); #1 i_reset = 1'b0;

        // Default lengths 5/255/255/5/5.
        push_frame(5, 255, 255, 5, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 16'd1);
        pulse_start();
        wait_for(3, 2000, "default_frame");
        chk("default_busy_after", 32'(o_busy), 32'd0);

        // Programmed lengths 2/3/4/1.
        cfg(2'd0, 8'd2); cfg(2'd1, 8'd3); cfg(2'd2, 8'd4); cfg(2'd3, 8'd1);
        set_pix(8'h11, 8'h22, 8'h33, 8'h44);
        push_frame(2, 3, 4, 1, 8'h11, 8'h22, 8'h33, 8'h44, 16'd2);
        pulse_start();
        wait_for(3, 200, "prog_frame");

        // All lengths zero: every phase one cycle.
        cfg(2'd0, 8'd0); cfg(2'd1, 8'd0); cfg(2'd2, 8'd0); cfg(2'd3, 8'd0);
        set_pix(8'h5A, 8'hC3, 8'h0F, 8'hF0);
        push_frame(0, 0, 0, 0, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 16'd3);
        pulse_start();
        wait_for(3, 200, "zero_frame");

        // Toggling ready during drain.
        set_pix(8'h01, 8'h80, 8'h7E, 8'hE7);
        push_frame(0, 0, 0, 0, 8'h01, 8'h80, 8'h7E, 8'hE7, 16'd4);
        rdy_mode = 1;
        pulse_start();
        wait_for(3, 200, "stall_frame");
        rdy_mode = 0;
        i_out_ready = 1'b1;

        // Continuous: three frames, expose rewritten during frame 1.
        cfg(2'd0, 8'd1); cfg(2'd1, 8'd2); cfg(2'd2, 8'd1); cfg(2'd3, 8'd1);
        set_pix(8'h10, 8'h20, 8'h30, 8'h40);
        push_frame(1, 2, 1, 1, 8'h10, 8'h20, 8'h30, 8'h40, 16'd5);
        push_frame(1, 4, 1, 1, 8'h10, 8'h20, 8'h30, 8'h40, 16'd6);
        push_frame(1, 4, 1, 1, 8'h10, 8'h20, 8'h30, 8'h40, 16'd7);
        i_continuous = 1'b1;
        pulse_start();
        cfg(2'd1, 8'd4);
        wait_for(3, 200, "cont_frame1");
        chk("cont1_no_gap", 32'(o_erase), 32'd1);
        wait_for(3, 200, "cont_frame2");
        chk("cont2_no_gap", 32'(o_erase), 32'd1);
        i_continuous = 1'b0;
        wait_for(3, 200, "cont_frame3");
        chk("cont3_stop", 32'({o_erase, o_busy}), 32'd0);

        // Abort during CONVERT.
        ph_en = 1'b0;
        pq.delete();
        cfg(2'd0, 8'd2); cfg(2'd1, 8'd3); cfg(2'd2, 8'd10); cfg(2'd3, 8'd2);
        pulse_start();
        wait_for(0, 100, "abort_convert");
        pulse_abort();
        @(negedge clk);
        chk_idle_outputs("abort_convert", 16'd7);

        // Abort during DRAIN with downstream stalled.
        set_pix(8'h9C, 8'h9D, 8'h9E, 8'h9F);
        rdy_mode = 2;
        i_out_ready = 1'b0;
        wq.push_back('{8'h9C, 2'd0});
        pulse_start();
        wait_for(1, 100, "abort_drain");
        pulse_abort();
        @(negedge clk);
        chk_idle_outputs("abort_drain", 16'd7);
        wq.delete();
        rdy_mode = 0;
        i_out_ready = 1'b1;

        // Abort and start together: stays idle.
        @(posedge clk); #1 i_start = 1'b1; i_abort = 1'b1;
        @(posedge clk); #1 i_start = 1'b0; i_abort = 1'b0;
        @(negedge clk);
        chk_idle_outputs("abort_start", 16'd7);

        // Asynchronous reset mid-EXPOSE.
        cfg(2'd1, 8'd50);
        pulse_start();
        wait_for(2, 100, "reset_expose");
        #1 i_reset = 1'b1;
        #1;
        chk_idle_outputs("async_reset", 16'd0);
        chk("async_reset_data", 32'({o_out_data, o_out_idx}), 32'd0);
        @(posedge clk); #1 i_reset = 1'b0;
        @(negedge clk); #1 ph_en = 1'b1;

        // After reset the default lengths must be back.
        set_pix(8'hB1, 8'hB2, 8'hB3, 8'hB4);
        push_frame(5, 255, 255, 5, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 16'd1);
        pulse_start();
        wait_for(3, 2000, "post_reset_frame");
        repeat (3) @(negedge clk);

        chk("phase_queue_empty", 32'(pq.size()), 32'd0);
        chk("word_queue_empty", 32'(wq.size()), 32'd0);
        chk("done_queue_empty", 32'(dq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
